// File: rtl/rr_grant_arbiter.sv
// rr_grant_arbiter: round-robin one-hot grant with forced idle gap; optional hold timeout via RR_GRANT_ARBITER_TIMEOUT_EN
module rr_grant_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int HOLD_MAX = 16,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic               any_req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IW-1:0]      grant_idx,
    output logic               timeout
);
    typedef enum logic {IDLE, BUSY} state_t;

    if (NUM_REQ < 1 || NUM_REQ > 32 || HOLD_MAX < 2) begin : g_bad_param
        $error("rr_grant_arbiter: illegal NUM_REQ or HOLD_MAX");
    end

    state_t             state, state_n;
    logic [IW-1:0]      ptr, ptr_n, pick, idx_n, k, nxt;
    logic [NUM_REQ-1:0] grant_n;
    logic               valid_n, found, rel, expire;

    assign any_req = |req;
    assign rel     = done | ~req[grant_idx];
    assign nxt     = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // first asserted request scanning upward from ptr, wrapping at the top
    always_comb begin
        pick  = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = IW'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[k]) begin
                pick  = k;
                found = 1'b1;
            end
        end
    end

    // next state: grant from IDLE, release (or expiry) back to IDLE and advance ptr
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        grant_n = grant;
        idx_n   = grant_idx;
        valid_n = grant_valid;
        if (state == IDLE) begin
            if (any_req) begin
                state_n = BUSY;
                grant_n = NUM_REQ'(1) << pick;
                idx_n   = pick;
                valid_n = 1'b1;
            end
        end else if (rel || expire) begin
            state_n = IDLE;
            grant_n = '0;
            valid_n = 1'b0;
            ptr_n   = nxt;
        end
    end

    // state and grant registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            grant       <= grant_n;
            grant_idx   <= idx_n;
            grant_valid <= valid_n;
        end
    end

`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0] cnt;

    assign expire = (state == BUSY) && (cnt == CW'(HOLD_MAX - 1));

    // hold counter restarts every grant; timeout pulses only when expiry beats a release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            cnt     <= (state == BUSY) ? cnt + 1'b1 : '0;
            timeout <= expire & ~rel;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif
endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Round-robin arbiter sharing one downstream resource (e.g. a single synchronizer channel or bus port) among `NUM_REQ` requesters. It uses an N-to-1 OR reduction of the request vector to detect pending work. It issues one registered one-hot grant at a time, holds it until the owner releases, and always inserts one idle cycle between owners. It sits between the requesting blocks and the shared datapath, in front of the CDC channel mux.

## Interface
Parameters:
- `NUM_REQ`, default 8: number of requesters; legal range 1..32.
- `HOLD_MAX`, default 16: maximum grant length in cycles before forced revoke; legal range ≥2. Used only with the timeout feature.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `req`  input  NUM_REQ: level request per requester.
- `done`  input  1: one-cycle release pulse from the current owner.
- `any_req`  output  1: combinational OR of all `req` bits.
- `grant`  output  NUM_REQ: registered one-hot grant; all zeros when idle.
- `grant_valid`  output  1: registered; equals OR of `grant`.
- `grant_idx`  output  max(1, $clog2(NUM_REQ)): registered binary index of the owner; holds the last owner while idle.
- `timeout`  output  1: one-cycle pulse when a grant is force-revoked.

## Operation
- Reset values: `grant`=0, `grant_valid`=0, `grant_idx`=0, `timeout`=0, state=IDLE, priority pointer `ptr`=0, hold counter=0. `any_req` follows `req` combinationally, including during reset.
- State IDLE:
  - If `any_req`=1 at an edge, grant the first asserted `req` bit scanning upward from `ptr`, wrapping from NUM_REQ-1 to 0.
  - Load `grant`, `grant_idx` and `grant_valid`=1, then go to BUSY.
  - Otherwise remain in IDLE.
- State BUSY, release: at an edge where `done`=1, or where `req[grant_idx]`=0:
  - clear `grant` and `grant_valid`;
  - set `ptr` = (grant_idx+1) mod NUM_REQ;
  - go to IDLE.
- No back-to-back handoff: at least one cycle with `grant_valid`=0 always separates two grants, even when other requests are pending.
- `done` sampled in IDLE is ignored.
- `done` and a dropped owner request on the same edge count as a single release.
- Requests from non-owners never affect BUSY.
- NUM_REQ=1: `ptr` stays 0, `grant_idx` is constant 0, and behaviour is otherwise identical.
- Reset asserted mid-grant: all outputs return to reset values immediately (asynchronous). `ptr` returns to 0.

## Timing
- Grant latency: `req` first sampled high at edge E, with the arbiter in IDLE, gives `grant` high after edge E. This is one cycle of latency.
- Release latency: `done` sampled at edge E gives `grant` low after E. The next grant comes no earlier than edge E+1.
- Full rotation: with all `req` held high and `done` pulsed once per grant, the owners are granted in the order 0,1,…,NUM_REQ-1,0.
- `timeout` is high for exactly one cycle, coincident with the first idle cycle.

## Configuration
- Macro `RR_GRANT_ARBITER_TIMEOUT_EN`.
- Defined:
  - An internal counter clears on grant and increments each BUSY cycle.
  - If no release occurs within `HOLD_MAX` BUSY cycles, the grant drops at the edge ending the HOLD_MAX-th cycle.
  - `ptr` advances as on a normal release, and `timeout` pulses.
  - A release on that same edge takes priority, and no `timeout` pulse is issued.
- Undefined: no counter is present, `timeout` is tied 0, and grants are held indefinitely.

## Test plan
- Reset check: assert `rst_n`=0 with `req`=8'hFF. Required: `grant`=0, `grant_valid`=0, `grant_idx`=0, `timeout`=0, `any_req`=1.
- Single request latency: `req`=8'h10 sampled at edge E. Required: `grant`=8'h10 and `grant_idx`=4 after E. Then `done` pulse at E+3: `grant`=0 after E+3.
- Round-robin fairness: hold `req`=8'hFF and pulse `done` one cycle after each grant. Required: grants 0→1→…→7→0, with exactly one idle cycle between each.
- Pointer skip and wrap: after owner 6 releases, set `req`=8'h05. Required: next grant is idx 0, and the one after that is idx 2.
- Implicit release and ignored done: owner 3 drops `req[3]` and the grant clears one edge later. A `done` pulse while idle causes no state change.
- Timeout (macro defined, HOLD_MAX=4): grant idx 1 with no release. Required: grant drops after 4 BUSY cycles, `timeout` pulses for 1 cycle, and the next grant starts from idx 2. Also assert `rst_n` mid-grant: outputs clear asynchronously.
